// File: rtl/button_step_pkg.sv
// Shared types and default timing constants for the button step controller.
// Holds the FSM state encoding and a small helper used for counter sizing.
package button_step_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce
   import button_step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // This sample is the DEBOUNCE_CYCLES-th differing one: accept the new level.
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_step_ctrl.sv
// Turns two raw push-buttons into single step pulses plus a direction for an up/down counter,
// with auto-repeat while a button is held and a lockout when both buttons are pressed.
module button_step_ctrl
   import button_step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic repeat_en,
   output logic en,
   output logic up,
   output logic pressed
);

   localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

   logic          db_up;
   logic          db_down;
   logic          lvl_up;
   logic          lvl_down;
   logic          prev_up;
   logic          prev_down;
   state_t        state;
   state_t        state_nx;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nx;
   logic          en_nx;
   logic          up_nx;
   logic          rise_up;
   logic          rise_down;
   logic          active;
   logic          other;
   logic          expired;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_up),
      .level (db_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_down),
      .level (db_down)
   );

   // Debounced levels are re-registered so edge detection and pressed share one pipeline stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_up    <= 1'b0;
         lvl_down  <= 1'b0;
         prev_up   <= 1'b0;
         prev_down <= 1'b0;
         pressed   <= 1'b0;
         state     <= ST_IDLE;
         timer     <= '0;
         en        <= 1'b0;
         up        <= 1'b1;
      end else begin
         lvl_up    <= db_up;
         lvl_down  <= db_down;
         prev_up   <= lvl_up;
         prev_down <= lvl_down;
         pressed   <= db_up | db_down;
         state     <= state_nx;
         timer     <= timer_nx;
         en        <= en_nx;
         up        <= up_nx;
      end
   end

   assign rise_up   = lvl_up & ~prev_up;
   assign rise_down = lvl_down & ~prev_down;
   assign active    = up ? lvl_up : lvl_down;
   assign other     = up ? lvl_down : lvl_up;
   assign expired   = (timer == TW'(1));

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_nx = state;
      en_nx    = 1'b0;
      up_nx    = up;
      // The timer parks at 1 so a held expiry fires as soon as repeat_en returns.
      timer_nx = (timer > TW'(1)) ? timer - 1'b1 : timer;

      unique case (state)
         ST_IDLE: begin
            if ((rise_up && lvl_down) || (rise_down && lvl_up)) begin
               state_nx = ST_LOCK;
            end else if (rise_up || rise_down) begin
               en_nx    = 1'b1;
               up_nx    = rise_up;
               timer_nx = TW'(REPEAT_DELAY);
               state_nx = ST_DELAY;
            end
         end

         ST_DELAY, ST_REPEAT: begin
            if (other) begin
               state_nx = ST_LOCK;
            end else if (!active) begin
               // Release is checked before expiry so it wins a same-cycle tie.
               state_nx = ST_IDLE;
            end else if (expired && repeat_en) begin
               en_nx    = 1'b1;
               timer_nx = TW'(REPEAT_PERIOD);
               state_nx = ST_REPEAT;
            end
         end

         ST_LOCK: begin
            if (!lvl_up && !lvl_down) begin
               state_nx = ST_IDLE;
            end
         end

         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_button_step_ctrl.sv
// Randomised and directed bench for button_step_ctrl against a cycle-level behavioural model.
// The model tracks button history, press ownership and time since the last pulse.
module tb_button_step_ctrl;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic clk;
   logic reset;
   logic btn_up;
   logic btn_down;
   logic repeat_en;
   logic en;
   logic up;
   logic pressed;

   int total = 0;
   int bad   = 0;

   button_step_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .repeat_en (repeat_en),
      .en        (en),
      .up        (up),
      .pressed   (pressed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   property no_double_en;
      @(posedge clk) disable iff (reset) en |=> !en;
   endproperty
   assert property (no_double_en)
      else begin
         bad++;
         $display("FAIL en_consecutive t=%0t got en high twice want single pulse", $time);
      end

   // ---------------- behavioural reference model ----------------
   typedef enum {M_FREE, M_HELD, M_LOCK} mode_t;

   bit    pipe_up[$];
   bit    pipe_dn[$];
   int    run_up, run_dn;
   bit    m_db_up, m_db_dn, m_lvl_up, m_lvl_dn, m_prev_up, m_prev_dn;
   bit    m_en, m_up, m_pressed;
   bit    rise_u, rise_d, held, oth, s;
   mode_t mode;
   int    n, last, gap;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_up = {1'b0, 1'b0};
         pipe_dn = {1'b0, 1'b0};
         run_up = 0; run_dn = 0;
         m_db_up = 0; m_db_dn = 0; m_lvl_up = 0; m_lvl_dn = 0;
         m_prev_up = 0; m_prev_dn = 0;
         m_en = 0; m_up = 1; m_pressed = 0;
         mode = M_FREE; n = 0; last = 0; gap = RD;
      end else begin
         n++;
         m_en   = 0;
         rise_u = m_lvl_up && !m_prev_up;
         rise_d = m_lvl_dn && !m_prev_dn;
         case (mode)
            M_FREE: begin
               if ((rise_u && m_lvl_dn) || (rise_d && m_lvl_up)) mode = M_LOCK;
               else if (rise_u || rise_d) begin
                  m_en = 1; m_up = rise_u; last = n; gap = RD; mode = M_HELD;
               end
            end
            M_HELD: begin
               held = m_up ? m_lvl_up : m_lvl_dn;
               oth  = m_up ? m_lvl_dn : m_lvl_up;
               if (oth) mode = M_LOCK;
               else if (!held) mode = M_FREE;
               else if (repeat_en && (n - last >= gap)) begin
                  m_en = 1; last = n; gap = RP;
               end
            end
            default: if (!m_lvl_up && !m_lvl_dn) mode = M_FREE;
         endcase
         m_prev_up = m_lvl_up;
         m_prev_dn = m_lvl_dn;
         m_lvl_up  = m_db_up;
         m_lvl_dn  = m_db_dn;
         m_pressed = m_db_up | m_db_dn;
         // A raw sample reaches the debouncer two edges after it is captured.
         s = pipe_up.pop_front(); pipe_up.push_back(btn_up);
         if (s != m_db_up) begin
            run_up++;
            if (run_up == DB) begin m_db_up = s; run_up = 0; end
         end else run_up = 0;
         s = pipe_dn.pop_front(); pipe_dn.push_back(btn_down);
         if (s != m_db_dn) begin
            run_dn++;
            if (run_dn == DB) begin m_db_dn = s; run_dn = 0; end
         end else run_dn = 0;
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; btn_up = 0; btn_down = 0; repeat_en = 0;
      #3;
      total++;
      if ({en, up, pressed} !== 3'b010) begin
         bad++; $display("FAIL reset_async got=%b%b%b want=010", en, up, pressed);
      end
      repeat (3) @(posedge clk);
      #1 reset = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== 3'b010) begin
            bad++; $display("FAIL reset_idle k=%0d got=%b%b%b want=010", k, en, up, pressed);
         end
      end
   endtask

   task automatic test_single_press();
      int first_en = -1, first_pr = -1, pulses = 0;
      bit up_at = 0;
      btn_up = 1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL single_press k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en) begin pulses++; if (first_en < 0) begin first_en = k; up_at = up; end end
         if (pressed && first_pr < 0) first_pr = k;
         if (k == 9) btn_up = 0;
      end
      total++;
      if (first_en !== 7 || pulses !== 1 || up_at !== 1'b1) begin
         bad++; $display("FAIL single_press_edge got edge=%0d pulses=%0d up=%b want edge=7 pulses=1 up=1", first_en, pulses, up_at);
      end
      total++;
      if (first_pr !== 6) begin
         bad++; $display("FAIL single_press_pressed got=%0d want=6", first_pr);
      end
   endtask

   task automatic test_glitch();
      int first_en = -1;
      bit up_at = 1;
      btn_down = 1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (k == 2) btn_down = 0;
         total++;
         if ({en, up, pressed} !== 3'b010 || {m_en, m_up, m_pressed} !== 3'b010) begin
            bad++; $display("FAIL glitch k=%0d got=%b%b%b want=010", k, en, up, pressed);
         end
      end
      btn_down = 1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL down_press k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en && first_en < 0) begin first_en = k; up_at = up; end
         if (k == 11) btn_down = 0;
      end
      total++;
      if (first_en !== 7 || up_at !== 1'b0) begin
         bad++; $display("FAIL down_press_edge got edge=%0d up=%b want edge=7 up=0", first_en, up_at);
      end
   endtask

   task automatic test_repeat();
      int got[$];
      int exp_e[6] = '{7, 27, 35, 43, 51, 59};
      repeat_en = 1; btn_up = 1;
      for (int k = 0; k < 90; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL repeat k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en) got.push_back(k);
         if (k == 59) btn_up = 0;
      end
      total++;
      if (got.size() !== 6) begin
         bad++; $display("FAIL repeat_count got=%0d want=6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (got[i] !== exp_e[i]) begin
               bad++; $display("FAIL repeat_edge%0d got=%0d want=%0d", i, got[i], exp_e[i]);
            end
         end
      end
   endtask

   task automatic test_both();
      int pulses = 0, first_en = -1;
      btn_up = 1; btn_down = 1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL both k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en) pulses++;
         if (k == 19) btn_up = 0;
         if (k == 39) btn_down = 0;
      end
      total++;
      if (pulses !== 0) begin
         bad++; $display("FAIL both_lock got pulses=%0d want=0", pulses);
      end
      btn_up = 1;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL after_lock k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en && first_en < 0) first_en = k;
         if (k == 11) btn_up = 0;
      end
      total++;
      if (first_en !== 7) begin
         bad++; $display("FAIL after_lock_edge got=%0d want=7", first_en);
      end
   endtask

   task automatic test_reset_mid();
      int first_en = -1;
      repeat_en = 1; btn_up = 1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL pre_reset k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
      end
      reset = 1;
      #1;
      total++;
      if ({en, up, pressed} !== 3'b010) begin
         bad++; $display("FAIL reset_mid got=%b%b%b want=010", en, up, pressed);
      end
      @(posedge clk); #1 reset = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL post_reset k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en && first_en < 0) first_en = k;
         if (k == 19) btn_up = 0;
      end
      total++;
      if (first_en !== DB + 3) begin
         bad++; $display("FAIL post_reset_edge got=%0d want=%0d", first_en, DB + 3);
      end
   endtask

   task automatic test_release_expiry();
      int got[$];
      repeat_en = 1; btn_up = 1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         total++;
         if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
            bad++; $display("FAIL rel_expiry k=%0d got=%b%b%b want=%b%b%b", k, en, up, pressed, m_en, m_up, m_pressed);
         end
         if (en) got.push_back(k);
         if (k == 19) btn_up = 0;
      end
      total++;
      if (got.size() !== 1 || got[0] !== 7) begin
         bad++; $display("FAIL rel_expiry_pulses got count=%0d want single pulse at 7", got.size());
      end
   endtask

   task automatic test_random();
      int cyc = 0, dur, sel;
      while (cyc < 3000) begin
         sel = $urandom_range(0, 5);
         dur = $urandom_range(1, 45);
         btn_up    = (sel == 1) || (sel == 3) || (sel == 5 && dur[0]);
         btn_down  = (sel == 2) || (sel == 3) || (sel == 5 && !dur[0]);
         repeat_en = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < dur; k++) begin
            @(posedge clk); #1;
            cyc++;
            total++;
            if ({en, up, pressed} !== {m_en, m_up, m_pressed}) begin
               bad++; $display("FAIL random cyc=%0d got=%b%b%b want=%b%b%b", cyc, en, up, pressed, m_en, m_up, m_pressed);
            end
         end
      end
      btn_up = 0; btn_down = 0;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_repeat();
      test_both();
      test_reset_mid();
      test_release_expiry();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
